// File: rtl/inst_encoder.sv
// inst_encoder: builds RV32I/Zicsr instruction words from decoded fields
// and an immediate, flags out-of-range immediates, 2-entry skid output.
module inst_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             I_clk,
    input  logic             I_rst,
    input  logic             I_in_valid,
    output logic             O_in_ready,
    input  logic [2:0]       I_fmt,
    input  logic [6:0]       I_opcode,
    input  logic [4:0]       I_rd,
    input  logic [4:0]       I_rs1,
    input  logic [4:0]       I_rs2,
    input  logic [2:0]       I_funct3,
    input  logic [6:0]       I_funct7,
    input  logic [11:0]      I_csr,
    input  logic [31:0]      I_imm,
    output logic             O_out_valid,
    input  logic             I_out_ready,
    output logic [31:0]      O_inst,
    output logic             O_err,
    output logic [CNT_W-1:0] O_word_cnt,
    output logic [ERR_W-1:0] O_err_cnt
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;

    logic [31:0] enc_inst;
    logic        enc_err;
    logic        accept;

    logic        out_valid;
    logic [31:0] out_inst;
    logic        out_err;
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic        skid_err;

    logic [CNT_W-1:0] word_cnt;
    logic [ERR_W-1:0] err_cnt;

    // Scatter the immediate into the chosen format and range-check it
    always_comb begin
        enc_inst = 32'h0;
        enc_err  = 1'b0;
        unique case (I_fmt)
            FMT_R: begin
                enc_inst = {I_funct7, I_rs2, I_rs1, I_funct3, I_rd, I_opcode};
            end
            FMT_I: begin
                enc_inst = {I_imm[11:0], I_rs1, I_funct3, I_rd, I_opcode};
                enc_err  = I_imm[31:11] != {21{I_imm[11]}};
            end
            FMT_S: begin
                enc_inst = {I_imm[11:5], I_rs2, I_rs1, I_funct3,
                            I_imm[4:0], I_opcode};
                enc_err  = I_imm[31:11] != {21{I_imm[11]}};
            end
            FMT_B: begin
                enc_inst = {I_imm[12], I_imm[10:5], I_rs2, I_rs1, I_funct3,
                            I_imm[4:1], I_imm[11], I_opcode};
                enc_err  = (I_imm[31:12] != {20{I_imm[12]}}) || I_imm[0];
            end
            FMT_U: begin
                enc_inst = {I_imm[31:12], I_rd, I_opcode};
                enc_err  = |I_imm[11:0];
            end
            FMT_J: begin
                enc_inst = {I_imm[20], I_imm[10:1], I_imm[11], I_imm[19:12],
                            I_rd, I_opcode};
                enc_err  = (I_imm[31:20] != {12{I_imm[20]}}) || I_imm[0];
            end
            FMT_CSR: begin
                enc_inst = {I_csr, I_imm[4:0], I_funct3, I_rd, I_opcode};
                enc_err  = |I_imm[31:5];
            end
            default: begin
                enc_inst = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Ready depends only on the skid register, never on I_out_ready
    assign accept = I_in_valid && !skid_valid;

    // Output register plus skid entry; skid drains into output first
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            out_valid  <= 1'b0;
            out_inst   <= 32'h0;
            out_err    <= 1'b0;
            skid_valid <= 1'b0;
            skid_inst  <= 32'h0;
            skid_err   <= 1'b0;
        end else if (!out_valid || I_out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_inst   <= skid_inst;
                out_err    <= skid_err;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= accept;
                if (accept) begin
                    out_inst <= enc_inst;
                    out_err  <= enc_err;
                end
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_inst  <= enc_inst;
            skid_err   <= enc_err;
        end
    end

    // Count accepted bundles (wrapping) and violations (saturating)
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (enc_err && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

    assign O_in_ready  = !skid_valid;
    assign O_out_valid = out_valid;
    assign O_inst      = out_inst;
    assign O_err       = out_err;
    assign O_word_cnt  = word_cnt;
    assign O_err_cnt   = err_cnt;

endmodule
